wb_arbiter: RTL and testbench
=============================

Name: wb_arbiter

Overview:
- Write-back arbiter feeding the single write/unlock port of the integer/FP scoreboarded register file.
- Collects results from NUM_PORTS execution units over valid/ready.
- Buffers one result per unit and drives at most one register write per cycle, with round-robin fairness.
- Sits between the execution units and the register file's write port, whose write also clears the destination lock.

Parameters:
- XLEN, 64, integer register width.
- FLEN, 32, floating point register width.
- NUM_PORTS, 4, number of execution-unit result ports; 2..8.
- MaxLen (localparam), max(XLEN, FLEN), data width of result and write buses.

Ports:
- clk_i  in  1  clock, rising edge.
- arst_ni  in  1  asynchronous active-low reset.
- res_addr_i  in  NUM_PORTS x 6  per-port destination address; bit 5 set = FP register, else integer.
- res_data_i  in  NUM_PORTS x MaxLen  per-port result data.
- res_valid_i  in  NUM_PORTS  per-port result valid.
- res_ready_o  out  NUM_PORTS  per-port result ready.
- wr_addr_o  out  6  register write / unlock address.
- wr_data_o  out  MaxLen  register write data.
- wr_en_o  out  1  register write / unlock enable.
- busy_o  out  1  any holding register occupied.

Clocking and reset: one clock (clk_i); reset is asynchronous and active-low (arst_ni).

Behaviour:
- State: per port hold_valid[i], hold_addr[i] (6b), hold_data[i] (MaxLen); round-robin pointer rr_ptr ($clog2(NUM_PORTS) bits).
- Reset: hold_valid all 0, rr_ptr 0, wr_en_o 0, wr_addr_o 0, wr_data_o 0, busy_o 0, res_ready_o all 1 (after reset release).
- Reset asserted mid-operation: all buffered results are discarded; no write is emitted.
- Accept: handshake on port i when res_valid_i[i] & res_ready_o[i] at the rising edge.
  - Result is captured into hold[i] and hold_valid[i] is set.
  - Valid must stay asserted with stable addr/data until ready.
- Ready: res_ready_o[i] = ~hold_valid[i] | gnt[i]. A port drained this cycle may accept a new result in the same cycle.
- Arbitration:
  - Among hold_valid, grant the first set index searching rr_ptr, rr_ptr+1, ... modulo NUM_PORTS.
  - At most one gnt per cycle.
  - On grant to i: hold_valid[i] clears at the edge unless refilled the same edge; rr_ptr <= (i+1) mod NUM_PORTS.
  - No grant: rr_ptr holds.
- Output (combinational from the granted holding register):
  - wr_en_o = |hold_valid.
  - wr_addr_o/wr_data_o = granted hold_addr/hold_data; all zero when wr_en_o = 0.
  - The register file accepts every write, so there is no backpressure on wr_en_o.
- Latency: handshake at edge N -> wr_en_o high in cycle N+1 if uncontended. Worst case NUM_PORTS cycles when all ports are pending.
- Throughput: one write per cycle sustained. A single port streaming back-to-back gets one write per cycle.
- Width: FP results use the low FLEN bits and integer results the low XLEN bits; the arbiter passes the full MaxLen unmodified.
- Address 0 writes (x0) are forwarded unchanged; the register file ignores the data and no lock exists for x0.
- Ordering: per port, strictly in order. Across ports, unordered; the scoreboard guarantees distinct outstanding destinations.
- busy_o = |hold_valid.

Optional Feature:
- Macro WB_ARB_BYPASS_EN.
- Defined: when no hold_valid is set, the first valid input searching from rr_ptr is driven combinationally onto wr_* in the same cycle.
  - Its res_ready_o is 1 and no capture occurs, giving 0-cycle latency.
  - rr_ptr advances past that port.
  - Other valid inputs that cycle are captured normally.
- Not defined: all results pass through the holding registers, giving the minimum 1-cycle latency above.

Test Plan:
- Reset: assert arst_ni=0 mid-stream with 3 holds valid -> wr_en_o=0, busy_o=0, rr_ptr=0, no write after release.
- Single port: port 2 sends addr 6'h05, data 64'hDEAD_BEEF at edge N -> wr_en_o=1, wr_addr_o=5, wr_data_o=DEAD_BEEF in cycle N+1 only (cycle N with WB_ARB_BYPASS_EN).
- Round robin: all 4 ports valid at the same edge (addr 1..4), rr_ptr=0 -> writes to 1,2,3,4 on four consecutive cycles; a new result on port 0 during this is written after port 3.
- Back-to-back: port 1 streams 8 results (addr 8..15) with valid held high -> res_ready_o[1] stays 1, eight consecutive writes, none lost or duplicated.
- FP/width: port 0 sends addr 6'h23, data 64'h0000_0000_3F80_0000 -> wr_addr_o=0x23, wr_data_o unchanged.
- Stall: port 3 holds an undrained result while 3 higher-priority grants occur -> res_ready_o[3]=0; addr/data remain stable until the granted cycle.

Source files
------------

// File: rtl/wb_arbiter.sv
// Round-robin write-back arbiter with one holding register per execution unit.
// Define WB_ARB_BYPASS_EN to write an input directly when all holds are empty.
module wb_arbiter #(
  parameter int XLEN      = 64,
  parameter int FLEN      = 32,
  parameter int NUM_PORTS = 4,
  localparam int MaxLen   = (XLEN > FLEN) ? XLEN : FLEN
) (
  input  logic                                clk_i,
  input  logic                                arst_ni,
  input  logic [NUM_PORTS-1:0][5:0]           res_addr_i,
  input  logic [NUM_PORTS-1:0][MaxLen-1:0]    res_data_i,
  input  logic [NUM_PORTS-1:0]                res_valid_i,
  output logic [NUM_PORTS-1:0]                res_ready_o,
  output logic [5:0]                          wr_addr_o,
  output logic [MaxLen-1:0]                   wr_data_o,
  output logic                                wr_en_o,
  output logic                                busy_o
);

  localparam int PtrW = $clog2(NUM_PORTS);

  logic [NUM_PORTS-1:0]              hold_valid_q, hold_valid_d;
  logic [NUM_PORTS-1:0][5:0]         hold_addr_q, hold_addr_d;
  logic [NUM_PORTS-1:0][MaxLen-1:0]  hold_data_q, hold_data_d;
  logic [PtrW-1:0]                   rr_ptr_q, rr_ptr_d;

  logic [NUM_PORTS-1:0] gnt;
  logic [NUM_PORTS-1:0] byp_gnt;
  logic [NUM_PORTS-1:0] accept;
  logic [PtrW-1:0]      idx;
  logic [PtrW-1:0]      h_sel;
  logic                 h_any;

  function automatic logic [PtrW-1:0] nxt(input logic [PtrW-1:0] p);
    nxt = PtrW'((int'(p) + 1) % NUM_PORTS);
  endfunction

  always_comb begin
    h_any = 1'b0;
    h_sel = '0;
    idx   = '0;
    gnt   = '0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      idx = PtrW'((int'(rr_ptr_q) + k) % NUM_PORTS);
      if (!h_any && hold_valid_q[idx]) begin
        h_any = 1'b1;
        h_sel = idx;
      end
    end
    if (h_any) gnt[h_sel] = 1'b1;
  end

`ifdef WB_ARB_BYPASS_EN
  logic [PtrW-1:0] b_idx;
  logic [PtrW-1:0] b_sel;
  logic            b_any;

  // Bypass only when nothing is buffered, so buffered results never lose order.
  always_comb begin
    b_any   = 1'b0;
    b_sel   = '0;
    b_idx   = '0;
    byp_gnt = '0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      b_idx = PtrW'((int'(rr_ptr_q) + k) % NUM_PORTS);
      if (!b_any && res_valid_i[b_idx]) begin
        b_any = 1'b1;
        b_sel = b_idx;
      end
    end
    if (b_any && !h_any) byp_gnt[b_sel] = 1'b1;
  end
`else
  assign byp_gnt = '0;
`endif

  assign res_ready_o = ~hold_valid_q | gnt;
  assign accept      = res_valid_i & res_ready_o & ~byp_gnt;
  assign busy_o      = |hold_valid_q;

  always_comb begin
    wr_en_o   = h_any;
    wr_addr_o = '0;
    wr_data_o = '0;
    rr_ptr_d  = rr_ptr_q;
    if (h_any) begin
      wr_addr_o = hold_addr_q[h_sel];
      wr_data_o = hold_data_q[h_sel];
      rr_ptr_d  = nxt(h_sel);
    end
`ifdef WB_ARB_BYPASS_EN
    else if (b_any) begin
      wr_en_o   = 1'b1;
      wr_addr_o = res_addr_i[b_sel];
      wr_data_o = res_data_i[b_sel];
      rr_ptr_d  = nxt(b_sel);
    end
`endif
  end

  always_comb begin
    hold_valid_d = hold_valid_q;
    hold_addr_d  = hold_addr_q;
    hold_data_d  = hold_data_q;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (accept[i]) begin
        hold_valid_d[i] = 1'b1;
        hold_addr_d[i]  = res_addr_i[i];
        hold_data_d[i]  = res_data_i[i];
      end else if (gnt[i]) begin
        hold_valid_d[i] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      hold_valid_q <= '0;
      hold_addr_q  <= '0;
      hold_data_q  <= '0;
      rr_ptr_q     <= '0;
    end else begin
      hold_valid_q <= hold_valid_d;
      hold_addr_q  <= hold_addr_d;
      hold_data_q  <= hold_data_d;
      rr_ptr_q     <= rr_ptr_d;
    end
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter in its default (buffered) build.
// Inputs change 1ns after a rising edge; outputs are checked before the next edge.
module tb_wb_arbiter;

  logic              clk = 1'b0;
  logic              arst_ni;
  logic [3:0][5:0]   addr;
  logic [3:0][63:0]  data;
  logic [3:0]        valid;
  logic [3:0]        ready;
  logic [5:0]        wr_addr;
  logic [63:0]       wr_data;
  logic              wr_en;
  logic              busy;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  wb_arbiter #(.XLEN(64), .FLEN(32), .NUM_PORTS(4)) dut (
    .clk_i       (clk),
    .arst_ni     (arst_ni),
    .res_addr_i  (addr),
    .res_data_i  (data),
    .res_valid_i (valid),
    .res_ready_o (ready),
    .wr_addr_o   (wr_addr),
    .wr_data_o   (wr_data),
    .wr_en_o     (wr_en),
    .busy_o      (busy)
  );

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    arst_ni = 1'b0;
    valid   = '0;
    addr    = '0;
    data    = '0;
    #3;
    chk("rst_en", wr_en, 0);
    chk("rst_busy", busy, 0);
    chk("rst_rdy", ready, 4'hF);
    chk("rst_addr", wr_addr, 0);
    #9 arst_ni = 1'b1;
    step();

    // single result on port 2
    valid[2] = 1'b1;
    addr[2]  = 6'h05;
    data[2]  = 64'hDEAD_BEEF;
    #1;
    chk("p2_rdy", ready[2], 1);
    chk("p2_pre_en", wr_en, 0);
    step();
    valid = '0;
    #1;
    chk("p2_en", wr_en, 1);
    chk("p2_addr", wr_addr, 6'h05);
    chk("p2_data", wr_data, 64'hDEAD_BEEF);
    chk("p2_busy", busy, 1);
    step();
    chk("p2_done_en", wr_en, 0);
    chk("p2_done_data", wr_data, 0);

    // port 3 once, pointer wraps back to 0
    valid[3] = 1'b1;
    addr[3]  = 6'h07;
    data[3]  = 64'h77;
    step();
    valid = '0;
    #1;
    chk("p3_addr", wr_addr, 6'h07);
    step();

    // all four ports at once, plus a late port-0 result
    for (int i = 0; i < 4; i++) begin
      valid[i] = 1'b1;
      addr[i]  = 6'(i + 1);
      data[i]  = 64'h100 + 64'(i);
    end
    step();
    valid    = '0;
    valid[0] = 1'b1;
    addr[0]  = 6'h11;
    data[0]  = 64'h5A5A;
    #1;
    chk("rr0_addr", wr_addr, 6'h01);
    chk("rr0_data", wr_data, 64'h100);
    chk("rr0_rdy0", ready[0], 1);
    chk("rr0_rdy3", ready[3], 0);
    step();
    valid = '0;
    #1;
    chk("rr1_addr", wr_addr, 6'h02);
    chk("rr1_data", wr_data, 64'h101);
    chk("rr1_rdy3", ready[3], 0);
    step();
    chk("rr2_addr", wr_addr, 6'h03);
    chk("rr2_rdy3", ready[3], 0);
    step();
    chk("rr3_addr", wr_addr, 6'h04);
    chk("rr3_data", wr_data, 64'h103);
    chk("rr3_rdy3", ready[3], 1);
    step();
    chk("rr4_addr", wr_addr, 6'h11);
    chk("rr4_data", wr_data, 64'h5A5A);
    step();
    chk("rr_idle_en", wr_en, 0);
    chk("rr_idle_busy", busy, 0);

    // port 1 streams back-to-back
    valid[1] = 1'b1;
    for (int k = 0; k < 8; k++) begin
      addr[1] = 6'(8 + k);
      data[1] = 64'h1000 + 64'(k);
      #1;
      chk("bb_rdy", ready[1], 1);
      step();
      chk("bb_en", wr_en, 1);
      chk("bb_addr", wr_addr, 64'(8 + k));
      chk("bb_data", wr_data, 64'h1000 + 64'(k));
    end
    valid = '0;
    step();
    chk("bb_done_en", wr_en, 0);

    // FP destination, full-width data passes untouched
    valid[0] = 1'b1;
    addr[0]  = 6'h23;
    data[0]  = 64'h0000_0000_3F80_0000;
    step();
    valid = '0;
    #1;
    chk("fp_addr", wr_addr, 6'h23);
    chk("fp_data", wr_data, 64'h0000_0000_3F80_0000);
    step();

    // reset with three holds occupied
    for (int i = 0; i < 3; i++) begin
      valid[i] = 1'b1;
      addr[i]  = 6'(6'h0A + i);
      data[i]  = 64'hF0 + 64'(i);
    end
    step();
    valid = '0;
    #1;
    chk("mr_busy", busy, 1);
    chk("mr_addr", wr_addr, 6'h0B);
    #2 arst_ni = 1'b0;
    #1;
    chk("mr_en", wr_en, 0);
    chk("mr_busy0", busy, 0);
    chk("mr_rdy", ready, 4'hF);
    step();
    step();
    arst_ni = 1'b1;
    step();
    chk("mr_post_en", wr_en, 0);
    chk("mr_post_busy", busy, 0);

    // pointer back at 0: port 0 wins over port 1
    valid[0] = 1'b1;
    addr[0]  = 6'h09;
    valid[1] = 1'b1;
    addr[1]  = 6'h0A;
    step();
    valid = '0;
    #1;
    chk("ptr0_first", wr_addr, 6'h09);
    step();
    chk("ptr0_second", wr_addr, 6'h0A);
    step();
    chk("ptr0_idle", wr_en, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
